multimode_shift_counter: RTL and testbench
==========================================

// Module: multimode_shift_counter
// PURPOSE
//  Parametrised successor of the lab 8-bit register/counter. It drives board LEDs/displays.
//  One WIDTH-bit register q advances one step per prescaled tick.
//  Step modes: shift, rotate, Johnson, up count or down count.
//  Also provides synchronous parallel load, a step strobe and a wrap strobe for cascading.
// PARAMETERS
//  WIDTH  8            register width, >=2
//  DIV    1            enabled clk cycles per step, >=1 (1 = step every enabled cycle)
//  INIT   {WIDTH{..01}} reset value of q (default 1 in LSB)
// PORTS
//  clk   in   1      rising-edge clock, single clock domain
//  rst   in   1      asynchronous, active-high reset
//  en    in   1      advance enable (prescaler counts only while high)
//  mode  in   3      step mode, encoding in package
//  load  in   1      synchronous parallel load strobe
//  d     in   WIDTH  parallel load data
//  sin   in   1      serial input for SHL/SHR
//  q     out  WIDTH  register value
//  tick  out  1      registered, 1 cycle: q was stepped at this edge
//  wrap  out  1      registered, 1 cycle: step completed a cycle/overflow
// BEHAVIOUR
//  - Reset (async, immediate): q=INIT, prescaler=0, tick=0, wrap=0. Holds while rst=1.
//  - Priority per edge: rst > load > en.
//  - load=1: q<=d, prescaler<=0, tick<=0, wrap<=0. Applies regardless of en, mode or a pending step.
//  - load=0, en=1:
//    - If prescaler==DIV-1: step (q<=next(mode,q)), prescaler<=0, tick<=1.
//    - Otherwise: prescaler++, tick<=0, wrap<=0.
//  - load=0, en=0: q, prescaler held; tick<=0, wrap<=0.
//  - Latency: q, tick and wrap update on the same edge. A step occurs DIV enabled cycles after load/reset.
//  - next(mode,q):
//    - 0 HOLD: q (tick still pulses)
//    - 1 SHL: {q[W-2:0],sin}
//    - 2 SHR: {sin,q[W-1:1]}
//    - 3 ROTL: {q[W-2:0],q[W-1]}
//    - 4 ROTR: {q[0],q[W-1:1]}
//    - 5 JOHN: {q[W-2:0],~q[W-1]}
//    - 6 UP: q+1 mod 2^W
//    - 7 DOWN: q-1 mod 2^W
//  - wrap (set only on a step edge):
//    - ROTL/ROTR/JOHN: next==INIT
//    - UP: q==all-ones
//    - DOWN: q==0
//    - HOLD/SHL/SHR: 0
//  - Rotate of all-zero q stays 0, with no wrap unless INIT==0.
//  - Mode change mid-count: prescaler is not reset. The new mode applies at the next step.
//  - Unused/illegal patterns: none (all 8 codes defined).
//  - Prescaler width is max(1,$clog2(DIV)). With DIV=1 the prescaler is constant 0.
//  - rst asserted mid-count: immediate return to reset state. The partial prescale is discarded.
// STRUCTURE
//  - Package multimode_shift_pkg:
//    - mode_e 3-bit enum: HOLD,SHL,SHR,ROTL,ROTR,JOHN,UP,DOWN
//    - MODE_W=3
//  - Sub-module tick_prescaler:
//    - Params: DIV.
//    - Ports: clk, rst, en, clr, step (combinational: en && cnt==DIV-1).
//  - Top: combinational next-state/wrap function plus q/tick/wrap registers.
// TESTING (WIDTH=8, INIT=8'h01 unless noted)
//  1 Reset: rst=1 mid-cycle -> q=8'h01, tick=0, wrap=0 before next clk edge. Hold across edges.
//  2 ROTL, DIV=1, en=1 x8 -> q=02,04,08,10,20,40,80,01.
//    - tick=1 every cycle.
//    - wrap=1 only with q=01.
//  3 JOHN, DIV=1, load d=00, then 16 steps:
//    - q=01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00.
//    - wrap=1 only at q=01.
//  4 UP, DIV=4, load d=FE, en=1 12 cycles:
//    - q=FF at cycle 4 and q=00 at cycle 8, with wrap=1 there.
//    - tick pulses at cycles 4, 8, 12 only.
//  5 DOWN from load 00 -> q=FF, wrap=1.
//    - Assert load d=5A on the same edge a step is due -> q=5A, tick=0.
//    - Next step after DIV cycles.
//  6 SHR, sin=1, load 00, DIV=2:
//    - q=80 after 2 cycles.
//    - en=0 for 5 cycles -> q stays 80, tick=0.
//    - en=1 -> q=C0 after 2 more cycles.

Source files
------------

// File: rtl/multimode_shift_pkg.sv
// Shared types for the multimode shift/count register: step-mode encoding
// and a helper that classifies modes whose wrap strobe compares against INIT.
package multimode_shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    ROTL = 3'd3,
    ROTR = 3'd4,
    JOHN = 3'd5,
    UP   = 3'd6,
    DOWN = 3'd7
  } mode_e;

  // Cyclic modes report a wrap when the register returns to its reset pattern.
  function automatic logic wraps_on_init(input mode_e m);
    return (m == ROTL) || (m == ROTR) || (m == JOHN);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by DIV; step is high on the enabled cycle
// that completes a prescale period. clr restarts the period.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // With DIV=1 LAST is zero, so cnt never leaves 0 and step simply follows en.
  assign step = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multimode_shift_counter.sv
// WIDTH-bit register that shifts, rotates, Johnson-counts or up/down counts
// once per prescaled tick, with parallel load and tick/wrap strobes for cascading.
module multimode_shift_counter
  import multimode_shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DIV   = 1,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic              tick,
  output logic              wrap
);

  mode_e            step_mode;
  logic             step;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign step_mode = mode_e'(mode);

  // load doubles as the prescaler clear so a step is due DIV cycles after it.
  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    case (step_mode)
      HOLD: q_next = q;
      SHL:  q_next = {q[WIDTH-2:0], sin};
      SHR:  q_next = {sin, q[WIDTH-1:1]};
      ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ROTR: q_next = {q[0], q[WIDTH-1:1]};
      JOHN: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
      UP: begin
        q_next    = q + WIDTH'(1);
        wrap_next = &q;
      end
      DOWN: begin
        q_next    = q - WIDTH'(1);
        wrap_next = ~|q;
      end
      default: q_next = q;
    endcase
    if (wraps_on_init(step_mode)) wrap_next = (q_next == INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= INIT;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      q    <= q_next;
      tick <= 1'b1;
      wrap <= wrap_next;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Bench for multimode_shift_counter: three instances (DIV=1,2,4) share stimulus and
// are compared every cycle against an arithmetic model, plus directed literal checks.
module tb_multimode_shift_counter;

  localparam logic [7:0] INIT = 8'h01;

  logic       clk = 1'b0;
  logic       rst, en, load, sin;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q1, q2, q4;
  logic       t1, t2, t4, w1, w2, w4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multimode_shift_counter #(.WIDTH(8), .DIV(1), .INIT(INIT)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d), .sin(sin),
    .q(q1), .tick(t1), .wrap(w1));
  multimode_shift_counter #(.WIDTH(8), .DIV(2), .INIT(INIT)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d), .sin(sin),
    .q(q2), .tick(t2), .wrap(w2));
  multimode_shift_counter #(.WIDTH(8), .DIV(4), .INIT(INIT)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d), .sin(sin),
    .q(q4), .tick(t4), .wrap(w4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int div_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  // Returns {wrap, next} using integer arithmetic on the register value.
  function automatic logic [8:0] model_step(input int m, input logic [7:0] qv, input logic s);
    int v = int'(qv);
    int si = s ? 1 : 0;
    int n = v;
    bit w = 1'b0;
    case (m)
      1: n = (v * 2) % 256 + si;
      2: n = v / 2 + si * 128;
      3: n = (v * 2) % 256 + v / 128;
      4: n = v / 2 + (v % 2) * 128;
      5: n = (v * 2) % 256 + (1 - v / 128);
      6: begin n = (v + 1) % 256; w = (v + 1 == 256); end
      7: begin n = (v + 255) % 256; w = (v == 0); end
      default: n = v;
    endcase
    if (m == 3 || m == 4 || m == 5) w = (n == int'(INIT));
    return {w, 8'(n)};
  endfunction

  logic [7:0] m_q    [3];
  int         m_pre  [3];
  logic       m_tick [3];
  logic       m_wrap [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_q[i] = INIT; m_pre[i] = 0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
      end else if (load) begin
        m_q[i] = d; m_pre[i] = 0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
      end else if (en && m_pre[i] + 1 == div_of(i)) begin
        logic [8:0] r;
        r = model_step(int'(mode), m_q[i], sin);
        m_q[i] = r[7:0]; m_wrap[i] = r[8]; m_tick[i] = 1'b1; m_pre[i] = 0;
      end else begin
        if (en) m_pre[i] = m_pre[i] + 1;
        m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("model_q_d1", 32'(q1), 32'(m_q[0]));
    check("model_tick_d1", 32'(t1), 32'(m_tick[0]));
    check("model_wrap_d1", 32'(w1), 32'(m_wrap[0]));
    check("model_q_d2", 32'(q2), 32'(m_q[1]));
    check("model_tick_d2", 32'(t2), 32'(m_tick[1]));
    check("model_wrap_d2", 32'(w2), 32'(m_wrap[1]));
    check("model_q_d4", 32'(q4), 32'(m_q[2]));
    check("model_tick_d4", 32'(t4), 32'(m_tick[2]));
    check("model_wrap_d4", 32'(w4), 32'(m_wrap[2]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rotl_exp [8];
  logic [7:0] john_exp [16];
  logic [7:0] up_exp;

  initial begin
    rotl_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    john_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    rst = 1'b1; en = 1'b0; load = 1'b0; sin = 1'b0; mode = 3'd0; d = 8'h00;

    // Reset held across edges.
    repeat (2) cyc();
    check("reset_q", 32'(q1), 32'h01);
    check("reset_tick", 32'(t1), 32'h0);
    check("reset_wrap", 32'(w4), 32'h0);
    rst = 1'b0;

    // ROTL, DIV=1.
    mode = 3'd3; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("rotl_q", 32'(q1), 32'(rotl_exp[k]));
      check("rotl_tick", 32'(t1), 32'h1);
      check("rotl_wrap", 32'(w1), (k == 7) ? 32'h1 : 32'h0);
    end

    // JOHN from 00, DIV=1.
    load = 1'b1; d = 8'h00; cyc();
    check("john_load_q", 32'(q1), 32'h00);
    check("john_load_tick", 32'(t1), 32'h0);
    load = 1'b0; mode = 3'd5;
    for (int k = 0; k < 16; k++) begin
      cyc();
      check("john_q", 32'(q1), 32'(john_exp[k]));
      check("john_wrap", 32'(w1), (k == 0) ? 32'h1 : 32'h0);
    end

    // UP from FE, DIV=4.
    load = 1'b1; d = 8'hFE; cyc();
    load = 1'b0; mode = 3'd6;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      up_exp = 8'hFE + 8'(c / 4);
      check("up_q", 32'(q4), 32'(up_exp));
      check("up_tick", 32'(t4), (c % 4 == 0) ? 32'h1 : 32'h0);
      check("up_wrap", 32'(w4), (c == 8) ? 32'h1 : 32'h0);
    end

    // DOWN from 00, then load on the edge a DIV=4 step is due.
    load = 1'b1; d = 8'h00; mode = 3'd7; cyc();
    load = 1'b0; cyc();
    check("down_q", 32'(q1), 32'hFF);
    check("down_wrap", 32'(w1), 32'h1);
    repeat (2) cyc();
    check("down_d4_pending_q", 32'(q4), 32'h00);
    load = 1'b1; d = 8'h5A; cyc();
    check("load_over_step_q", 32'(q4), 32'h5A);
    check("load_over_step_tick", 32'(t4), 32'h0);
    load = 1'b0;
    repeat (3) cyc();
    check("after_load_wait_q", 32'(q4), 32'h5A);
    cyc();
    check("after_load_step_q", 32'(q4), 32'h59);
    check("after_load_step_tick", 32'(t4), 32'h1);

    // SHR with sin=1, DIV=2, including an en=0 stall.
    load = 1'b1; d = 8'h00; cyc();
    load = 1'b0; mode = 3'd2; sin = 1'b1;
    cyc();
    check("shr_half_q", 32'(q2), 32'h00);
    cyc();
    check("shr_q", 32'(q2), 32'h80);
    check("shr_tick", 32'(t2), 32'h1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("shr_stall_q", 32'(q2), 32'h80);
      check("shr_stall_tick", 32'(t2), 32'h0);
    end
    en = 1'b1;
    cyc();
    check("shr_resume_half_q", 32'(q2), 32'h80);
    cyc();
    check("shr_resume_q", 32'(q2), 32'hC0);
    check("shr_resume_tick", 32'(t2), 32'h1);

    // Asynchronous reset mid-cycle, mid-count.
    mode = 3'd6; cyc();
    #3 rst = 1'b1;
    #1;
    check("async_rst_q_d1", 32'(q1), 32'h01);
    check("async_rst_q_d4", 32'(q4), 32'h01);
    check("async_rst_tick", 32'(t1), 32'h0);
    cyc();
    check("rst_hold_q", 32'(q2), 32'h01);
    rst = 1'b0;

    // Randomized phase: model compare runs every cycle.
    for (int k = 0; k < 3000; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 15) == 0);
      d    = 8'($urandom);
      sin  = 1'($urandom);
      rst  = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
